// File: rtl/bloom_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bloom_scan_ctrl
// Brief    : Walks NOB blocks, fetches each comparator match vector and packs
//            the matching page indices into MAX_TPN result slots.
//            Optional macro BLOOM_SCAN_EARLY_STOP_EN: finish at the first
//            hit that cannot be stored instead of scanning every block.
// Revision : 1.0  initial release
// ============================================================================
module bloom_scan_ctrl #(
    parameter int NOB       = 64,
    parameter int PPB       = 64,
    parameter int MAX_TPN   = 8,
    parameter int NOP_WIDTH = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     num_patterns,
    output logic [2:0]                     cfg_k,
    output logic                           blk_req,
    output logic [$clog2(NOB)-1:0]         blk_addr,
    input  logic                           blk_vld,
    input  logic [PPB-1:0]                 eq_list,
    output logic [MAX_TPN*NOP_WIDTH-1:0]   res,
    output logic [$clog2(MAX_TPN+1)-1:0]   num_tpn,
    output logic                           overflow,
    output logic                           busy,
    output logic                           done
);

    localparam int ADDR_W = $clog2(NOB);
    localparam int CNT_W  = $clog2(MAX_TPN + 1);
    localparam int PAGE_W = $clog2(PPB);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SCAN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     cfg_k_q, cfg_k_d;
    logic [ADDR_W-1:0]              blk_addr_q, blk_addr_d;
    logic [PPB-1:0]                 hit_q, hit_d;
    logic [MAX_TPN*NOP_WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]               num_tpn_q, num_tpn_d;
    logic                           overflow_q, overflow_d;

    logic [2:0]                     w_cfg_k_dec;
    logic [PAGE_W-1:0]              w_lsb_idx;
    logic [NOP_WIDTH-1:0]           w_page;

    always_comb begin
        case (num_patterns)
            3'd2:    w_cfg_k_dec = 3'b001;
            3'd3:    w_cfg_k_dec = 3'b011;
            3'd4:    w_cfg_k_dec = 3'b111;
            default: w_cfg_k_dec = 3'b000;
        endcase
    end

    // Lowest set bit wins: scanning downwards leaves the smallest index last.
    always_comb begin
        w_lsb_idx = '0;
        for (int i = PPB - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                w_lsb_idx = PAGE_W'(i);
            end
        end
    end

    assign w_page = NOP_WIDTH'(blk_addr_q) * NOP_WIDTH'(PPB) + NOP_WIDTH'(w_lsb_idx);

    always_comb begin
        state_d    = state_q;
        cfg_k_d    = cfg_k_q;
        blk_addr_d = blk_addr_q;
        hit_d      = hit_q;
        res_d      = res_q;
        num_tpn_d  = num_tpn_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQ;
                    cfg_k_d    = w_cfg_k_dec;
                    blk_addr_d = '0;
                    num_tpn_d  = '0;
                    overflow_d = 1'b0;
                    res_d      = '0;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (blk_vld) begin
                    hit_d   = eq_list;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit_q != '0) begin
                    hit_d = hit_q & (hit_q - PPB'(1));
                    if (num_tpn_q < CNT_W'(MAX_TPN)) begin
                        for (int n = 0; n < MAX_TPN; n++) begin
                            if (num_tpn_q == CNT_W'(n)) begin
                                res_d[n*NOP_WIDTH +: NOP_WIDTH] = w_page;
                            end
                        end
                        num_tpn_d = num_tpn_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
`ifdef BLOOM_SCAN_EARLY_STOP_EN
                        state_d    = DONE;
`endif
                    end
                end else if (blk_addr_q == ADDR_W'(NOB - 1)) begin
                    state_d = DONE;
                end else begin
                    blk_addr_d = blk_addr_q + ADDR_W'(1);
                    state_d    = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_k_q    <= '0;
            blk_addr_q <= '0;
            hit_q      <= '0;
            res_q      <= '0;
            num_tpn_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_k_q    <= cfg_k_d;
            blk_addr_q <= blk_addr_d;
            hit_q      <= hit_d;
            res_q      <= res_d;
            num_tpn_q  <= num_tpn_d;
            overflow_q <= overflow_d;
        end
    end

    assign cfg_k    = cfg_k_q;
    assign blk_addr = blk_addr_q;
    assign res      = res_q;
    assign num_tpn  = num_tpn_q;
    assign overflow = overflow_q;
    assign blk_req  = (state_q == REQ);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule
`default_nettype wire
